regroup_bufid_manager: RTL and testbench

//  Free-list manager for packet-buffer IDs (bufids) in the last-node regroup path.

---
 rtl/regroup_bufid_manager.sv | 141 ++++++++++++++
 tb/tb_regroup_bufid_manager.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regroup_bufid_manager.sv
`default_nettype none
// ============================================================================
// Module      : regroup_bufid_manager
// Description : Free-list manager for packet-buffer IDs in the last-node
//               regroup path. Circular FIFO of free bufids, self-filled with
//               0..BUFID_NUM-1 after reset, one bufid presented at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module regroup_bufid_manager #(
    parameter int BUFID_W   = 9,
    parameter int BUFID_NUM = 512
) (
    input  logic               i_clk,
    input  logic               i_rst,
    output logic [BUFID_W-1:0] ov_bufid,
    output logic               o_bufid_wr,
    input  logic               i_bufid_ack,
    input  logic [BUFID_W-1:0] iv_release_bufid,
    input  logic               i_release_wr,
    output logic [BUFID_W:0]   ov_free_cnt,
    output logic               o_init_done,
    output logic               o_alloc_err_pulse,
    output logic               o_release_err_pulse
);

    localparam int                 PTR_W      = (BUFID_NUM > 1) ? $clog2(BUFID_NUM) : 1;
    localparam logic [PTR_W-1:0]   C_PTR_LAST = PTR_W'(BUFID_NUM - 1);
    localparam logic [BUFID_W:0]   C_CNT_FULL = (BUFID_W + 1)'(BUFID_NUM);
    localparam logic [BUFID_W:0]   C_CNT_ONE  = (BUFID_W + 1)'(1);

    typedef enum logic [0:0] {
        INIT_S = 1'b0,
        WORK_S = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [BUFID_W-1:0] r_mem [BUFID_NUM];
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [BUFID_W:0]   r_count;

    logic [PTR_W-1:0]   w_rd_ptr_nxt;
    logic [PTR_W-1:0]   w_wr_ptr_nxt;
    logic [BUFID_W:0]   w_count_nxt;
    logic               w_ack_ok;
    logic               w_rel_ok;
    logic               w_mem_we;
    logic [BUFID_W-1:0] w_mem_wdata;
    logic [BUFID_W-1:0] w_head_nxt;
    logic               w_bufid_wr_nxt;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == C_PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // Next-state, pointer/count update and next head selection
    always_comb begin
        w_state_nxt  = r_state;
        w_rd_ptr_nxt = r_rd_ptr;
        w_wr_ptr_nxt = r_wr_ptr;
        w_count_nxt  = r_count;
        w_ack_ok     = 1'b0;
        w_rel_ok     = 1'b0;
        w_mem_we     = 1'b0;
        w_mem_wdata  = iv_release_bufid;
        case (r_state)
            INIT_S: begin
                // Fill entry k with bufid k; the write pointer doubles as the value
                w_mem_we     = 1'b1;
                w_mem_wdata  = BUFID_W'(r_wr_ptr);
                w_wr_ptr_nxt = ptr_inc(r_wr_ptr);
                w_count_nxt  = r_count + C_CNT_ONE;
                if (r_wr_ptr == C_PTR_LAST) begin
                    w_state_nxt = WORK_S;
                end
            end
            default: begin
                w_ack_ok = i_bufid_ack && o_bufid_wr;
                // A simultaneous ack frees a slot, so a full list can still accept
                w_rel_ok = i_release_wr && ((r_count != C_CNT_FULL) || w_ack_ok);
                w_mem_we = w_rel_ok;
                if (w_ack_ok) begin
                    w_rd_ptr_nxt = ptr_inc(r_rd_ptr);
                end
                if (w_rel_ok) begin
                    w_wr_ptr_nxt = ptr_inc(r_wr_ptr);
                end
                if (w_ack_ok && !w_rel_ok) begin
                    w_count_nxt = r_count - C_CNT_ONE;
                end else if (w_rel_ok && !w_ack_ok) begin
                    w_count_nxt = r_count + C_CNT_ONE;
                end
            end
        endcase
        // Bypass: the new head is the slot being written this cycle
        if (w_rel_ok && (w_rd_ptr_nxt == r_wr_ptr)) begin
            w_head_nxt = iv_release_bufid;
        end else begin
            w_head_nxt = r_mem[w_rd_ptr_nxt];
        end
        w_bufid_wr_nxt = (r_state == WORK_S) && (w_count_nxt != '0);
    end

    // State, pointers, count and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state             <= INIT_S;
            r_rd_ptr            <= '0;
            r_wr_ptr            <= '0;
            r_count             <= '0;
            ov_bufid            <= '0;
            o_bufid_wr          <= 1'b0;
            o_init_done         <= 1'b0;
            o_alloc_err_pulse   <= 1'b0;
            o_release_err_pulse <= 1'b0;
        end else begin
            r_state             <= w_state_nxt;
            r_rd_ptr            <= w_rd_ptr_nxt;
            r_wr_ptr            <= w_wr_ptr_nxt;
            r_count             <= w_count_nxt;
            ov_bufid            <= w_bufid_wr_nxt ? w_head_nxt : '0;
            o_bufid_wr          <= w_bufid_wr_nxt;
            o_init_done         <= (r_state == WORK_S);
            o_alloc_err_pulse   <= i_bufid_ack && !o_bufid_wr;
            o_release_err_pulse <= i_release_wr && !w_rel_ok;
        end
    end

    // Free-list storage write port (contents need no reset; init refills it)
    always_ff @(posedge i_clk) begin
        if (w_mem_we) begin
            r_mem[r_wr_ptr] <= w_mem_wdata;
        end
    end

    assign ov_free_cnt = r_count;

endmodule
`default_nettype wire

// File: tb/tb_regroup_bufid_manager.sv
`default_nettype none
// ============================================================================
// Module      : tb_regroup_bufid_manager
// Description : Scoreboard bench for regroup_bufid_manager; a queue holds the
//               expected free list, popped and compared on each allocation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regroup_bufid_manager;

    localparam int BUFID_W   = 9;
    localparam int BUFID_NUM = 512;

    logic               clk;
    logic               rst;
    logic [BUFID_W-1:0] ov_bufid;
    logic               o_bufid_wr;
    logic               i_bufid_ack;
    logic [BUFID_W-1:0] iv_release_bufid;
    logic               i_release_wr;
    logic [BUFID_W:0]   ov_free_cnt;
    logic               o_init_done;
    logic               o_alloc_err_pulse;
    logic               o_release_err_pulse;

    int                 checks;
    int                 errors;
    logic [BUFID_W-1:0] model_q[$];
    logic [BUFID_W-1:0] exp_id;

    regroup_bufid_manager #(
        .BUFID_W   (BUFID_W),
        .BUFID_NUM (BUFID_NUM)
    ) u_dut (
        .i_clk               (clk),
        .i_rst               (rst),
        .ov_bufid            (ov_bufid),
        .o_bufid_wr          (o_bufid_wr),
        .i_bufid_ack         (i_bufid_ack),
        .iv_release_bufid    (iv_release_bufid),
        .i_release_wr        (i_release_wr),
        .ov_free_cnt         (ov_free_cnt),
        .o_init_done         (o_init_done),
        .o_alloc_err_pulse   (o_alloc_err_pulse),
        .o_release_err_pulse (o_release_err_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; observe 1 ns after the edge, then drive for the next
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic model_fill();
        model_q.delete();
        for (int k = 0; k < BUFID_NUM; k++) model_q.push_back(BUFID_W'(k));
    endtask

    // Release reset and count cycles until init completes; optional INIT-time pokes
    task automatic run_init(input string tag, input bit poke);
        int cyc;
        cyc = 0;
        rst = 1'b0;
        while (!o_init_done && cyc < 600) begin
            i_release_wr     = poke && (cyc == 9);
            iv_release_bufid = 9'd77;
            i_bufid_ack      = poke && (cyc == 19);
            cycle();
            cyc++;
            i_release_wr = 1'b0;
            i_bufid_ack  = 1'b0;
            if (poke && cyc == 10) begin
                checks++;
                if (o_release_err_pulse !== 1'b1) begin
                    errors++;
                    $display("FAIL %s_init_release_err got=%b exp=1", tag, o_release_err_pulse);
                end
            end
            if (poke && cyc == 20) begin
                checks++;
                if (o_alloc_err_pulse !== 1'b1) begin
                    errors++;
                    $display("FAIL %s_init_alloc_err got=%b exp=1", tag, o_alloc_err_pulse);
                end
            end
        end
        checks++;
        if (cyc != BUFID_NUM + 1 || o_bufid_wr !== 1'b1) begin
            errors++;
            $display("FAIL %s_init_latency got_cycles=%0d bufid_wr=%b exp_cycles=%0d bufid_wr=1",
                     tag, cyc, o_bufid_wr, BUFID_NUM + 1);
        end
        model_fill();
        checks++;
        if (ov_bufid !== model_q[0] || ov_free_cnt !== 10'(BUFID_NUM)) begin
            errors++;
            $display("FAIL %s_init_head got_id=%0d cnt=%0d exp_id=%0d cnt=%0d",
                     tag, ov_bufid, ov_free_cnt, model_q[0], BUFID_NUM);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle();
        cycle();
        checks++;
        if ({o_bufid_wr, o_init_done, o_alloc_err_pulse, o_release_err_pulse} !== 4'b0 ||
            ov_bufid !== '0 || ov_free_cnt !== '0) begin
            errors++;
            $display("FAIL reset_outputs got wr=%b done=%b aerr=%b rerr=%b id=%0d cnt=%0d exp all 0",
                     o_bufid_wr, o_init_done, o_alloc_err_pulse, o_release_err_pulse, ov_bufid, ov_free_cnt);
        end
        run_init("reset", 1'b0);
    endtask

    task automatic test_alloc_spaced();
        for (int i = 0; i < 3; i++) begin
            exp_id = model_q.pop_front();
            checks++;
            if (o_bufid_wr !== 1'b1 || ov_bufid !== exp_id) begin
                errors++;
                $display("FAIL spaced_head got wr=%b id=%0d exp wr=1 id=%0d", o_bufid_wr, ov_bufid, exp_id);
            end
            i_bufid_ack = 1'b1;
            cycle();
            i_bufid_ack = 1'b0;
            cycle();
            cycle();
        end
        checks++;
        if (ov_bufid !== model_q[0] || ov_free_cnt !== 10'd509 ||
            o_alloc_err_pulse !== 1'b0 || o_release_err_pulse !== 1'b0) begin
            errors++;
            $display("FAIL spaced_after got id=%0d cnt=%0d aerr=%b rerr=%b exp id=%0d cnt=509 errs 0",
                     ov_bufid, ov_free_cnt, o_alloc_err_pulse, o_release_err_pulse, model_q[0]);
        end
    endtask

    // Allocate back-to-back until empty, comparing every head with the scoreboard
    task automatic drain(input string tag);
        i_bufid_ack = 1'b1;
        while (model_q.size() > 0) begin
            exp_id = model_q.pop_front();
            checks++;
            if (o_bufid_wr !== 1'b1 || ov_bufid !== exp_id) begin
                errors++;
                $display("FAIL %s_drain got wr=%b id=%0d exp wr=1 id=%0d", tag, o_bufid_wr, ov_bufid, exp_id);
            end
            if (model_q.size() == 0) i_bufid_ack = 1'b1;
            cycle();
        end
        i_bufid_ack = 1'b0;
        checks++;
        if (o_bufid_wr !== 1'b0 || ov_free_cnt !== '0) begin
            errors++;
            $display("FAIL %s_empty got wr=%b cnt=%0d exp wr=0 cnt=0", tag, o_bufid_wr, ov_free_cnt);
        end
    endtask

    task automatic test_exhaust();
        drain("exhaust");
        i_bufid_ack = 1'b1;
        cycle();
        i_bufid_ack = 1'b0;
        checks++;
        if (o_alloc_err_pulse !== 1'b1) begin
            errors++;
            $display("FAIL exhaust_alloc_err got=%b exp=1", o_alloc_err_pulse);
        end
        i_release_wr     = 1'b1;
        iv_release_bufid = 9'd37;
        model_q.push_back(9'd37);
        cycle();
        i_release_wr = 1'b0;
        checks++;
        if (o_alloc_err_pulse !== 1'b0 || o_bufid_wr !== 1'b1 || ov_bufid !== model_q[0] ||
            ov_free_cnt !== 10'd1) begin
            errors++;
            $display("FAIL exhaust_bypass got aerr=%b wr=%b id=%0d cnt=%0d exp aerr=0 wr=1 id=%0d cnt=1",
                     o_alloc_err_pulse, o_bufid_wr, ov_bufid, ov_free_cnt, model_q[0]);
        end
    endtask

    task automatic test_full_release();
        i_release_wr = 1'b1;
        for (int k = 0; k < BUFID_NUM - 1; k++) begin
            iv_release_bufid = BUFID_W'(k);
            model_q.push_back(BUFID_W'(k));
            cycle();
        end
        iv_release_bufid = 9'd5;
        cycle();
        i_release_wr = 1'b0;
        checks++;
        if (o_release_err_pulse !== 1'b1 || ov_free_cnt !== 10'(BUFID_NUM)) begin
            errors++;
            $display("FAIL full_drop got rerr=%b cnt=%0d exp rerr=1 cnt=%0d",
                     o_release_err_pulse, ov_free_cnt, BUFID_NUM);
        end
        exp_id = model_q.pop_front();
        model_q.push_back(9'd5);
        checks++;
        if (ov_bufid !== exp_id) begin
            errors++;
            $display("FAIL full_head got=%0d exp=%0d", ov_bufid, exp_id);
        end
        i_bufid_ack  = 1'b1;
        i_release_wr = 1'b1;
        cycle();
        i_bufid_ack  = 1'b0;
        i_release_wr = 1'b0;
        checks++;
        if (o_release_err_pulse !== 1'b0 || o_alloc_err_pulse !== 1'b0 ||
            ov_free_cnt !== 10'(BUFID_NUM) || ov_bufid !== model_q[0]) begin
            errors++;
            $display("FAIL full_ack_release got rerr=%b aerr=%b cnt=%0d id=%0d exp 0 0 %0d %0d",
                     o_release_err_pulse, o_alloc_err_pulse, ov_free_cnt, ov_bufid, BUFID_NUM, model_q[0]);
        end
        drain("full");
    endtask

    task automatic test_single_swap();
        i_release_wr     = 1'b1;
        iv_release_bufid = 9'd7;
        model_q.push_back(9'd7);
        cycle();
        checks++;
        if (o_bufid_wr !== 1'b1 || ov_bufid !== model_q[0] || ov_free_cnt !== 10'd1) begin
            errors++;
            $display("FAIL swap_head7 got wr=%b id=%0d cnt=%0d exp wr=1 id=%0d cnt=1",
                     o_bufid_wr, ov_bufid, ov_free_cnt, model_q[0]);
        end
        exp_id = model_q.pop_front();
        model_q.push_back(9'd9);
        i_bufid_ack      = 1'b1;
        iv_release_bufid = 9'd9;
        cycle();
        i_bufid_ack  = 1'b0;
        i_release_wr = 1'b0;
        checks++;
        if (o_bufid_wr !== 1'b1 || ov_bufid !== model_q[0] || ov_free_cnt !== 10'd1) begin
            errors++;
            $display("FAIL swap_head9 got wr=%b id=%0d cnt=%0d exp wr=1 id=%0d cnt=1",
                     o_bufid_wr, ov_bufid, ov_free_cnt, model_q[0]);
        end
    endtask

    task automatic test_reset_mid();
        rst = 1'b1;
        cycle();
        run_init("reinit1", 1'b0);
        i_bufid_ack = 1'b1;
        for (int i = 0; i < 100; i++) begin
            exp_id = model_q.pop_front();
            checks++;
            if (ov_bufid !== exp_id) begin
                errors++;
                $display("FAIL mid_alloc got=%0d exp=%0d", ov_bufid, exp_id);
            end
            cycle();
        end
        rst = 1'b1;
        cycle();
        i_bufid_ack = 1'b0;
        checks++;
        if ({o_bufid_wr, o_init_done, o_alloc_err_pulse, o_release_err_pulse} !== 4'b0 ||
            ov_bufid !== '0 || ov_free_cnt !== '0) begin
            errors++;
            $display("FAIL mid_reset got wr=%b done=%b id=%0d cnt=%0d exp all 0",
                     o_bufid_wr, o_init_done, ov_bufid, ov_free_cnt);
        end
        run_init("reinit2", 1'b1);
        i_bufid_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_id = model_q.pop_front();
            checks++;
            if (ov_bufid !== exp_id) begin
                errors++;
                $display("FAIL reinit_alloc got=%0d exp=%0d", ov_bufid, exp_id);
            end
            cycle();
        end
        i_bufid_ack = 1'b0;
    endtask

    initial begin
        checks           = 0;
        errors           = 0;
        rst              = 1'b1;
        i_bufid_ack      = 1'b0;
        i_release_wr     = 1'b0;
        iv_release_bufid = '0;
        test_reset();
        test_alloc_spaced();
        test_exhaust();
        test_full_release();
        test_single_swap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
